// File: rtl/seg7_pkg.sv
// Shared 7-segment display definitions: segment patterns (active-low
// {g,f,e,d,c,b,a}), anode constants and small helpers for display blocks.
package seg7_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] bcd_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam logic [3:0] AN_OFF = 4'b1111;

   // Active-low one-hot anode pattern selecting digit position idx.
   function automatic logic [3:0] an_select(input logic [1:0] idx);
      an_select = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder. Codes 10..15 are not
// valid BCD and render as a centre dash so bad data is visible on the display.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  bcd_t i_bcd,
   output seg_t o_seg
);

   // Map each BCD code to its segment pattern; anything else shows a dash.
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A full frame of digits is captured once per scan rotation so the display
// never tears mid-frame. Each digit slot starts with a short all-off window
// to suppress ghosting. Optional leading-zero suppression on the leftmost
// digit and a blinking dp "colon" on the hours-units digit are provided.
// Requires CLK_HZ/DIGIT_HZ >= BLANK_CYC + 2.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned DIGIT_HZ  = 4_000,
   parameter int unsigned BLINK_HZ  = 1,
   parameter int unsigned BLANK_CYC = 1000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic       blank_lead,
   input  logic       dp_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned DIV   = CLK_HZ / DIGIT_HZ;
   localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned CNT_W = (DIV  > 1) ? $clog2(DIV)  : 1;
   localparam int unsigned BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(HALF - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [BLK_W-1:0] r_blk;
   logic             r_phase;
   bcd_t [3:0]       r_shadow;

   logic w_tick;
   logic w_blank;
   logic w_lead_sup;
   logic w_colon;
   bcd_t w_digit;
   seg_t w_seg;

   assign w_tick     = (r_cnt == CNT_LAST);
   assign w_blank    = (r_cnt < CNT_BLANK);
   assign w_digit    = r_shadow[r_idx];
   assign w_lead_sup = blank_lead && (r_idx == 2'd3) && (r_shadow[3] == 4'd0);
   assign w_colon    = dp_en && r_phase && (r_idx == 2'd2);

   bcd_to_seg7 u_dec (
      .i_bcd (w_digit),
      .o_seg (w_seg)
   );

   // Slot counter: free-running 0..DIV-1, one wrap per digit slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Scan index advances once per slot and wraps naturally after digit 3.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= 2'd0;
      end else if (w_tick) begin
         r_idx <= r_idx + 2'd1;
      end else begin
         r_idx <= r_idx;
      end
   end

   // Capture a whole frame only at the end of the last slot, so inputs that
   // change mid-frame never appear partially on the display.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
      end else if (w_tick && (r_idx == 2'd3)) begin
         r_shadow <= {d3, d2, d1, d0};
      end else begin
         r_shadow <= r_shadow;
      end
   end

   // Free-running blink timer for the colon, independent of the scan.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blk   <= '0;
         r_phase <= 1'b0;
      end else if (r_blk == BLK_LAST) begin
         r_blk   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_blk   <= r_blk + BLK_W'(1);
         r_phase <= r_phase;
      end
   end

   // Registered display outputs from the current slot state; blank window
   // and a suppressed leading zero both switch every anode off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else if (w_blank || w_lead_sup) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_select(r_idx);
         seg <= w_seg;
         dp  <= ~w_colon;
      end
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for the Basys3 4-digit common-anode 7-segment display.
- Sits directly downstream of the 24 h clock counter and consumes its four BCD digits (hours tens/units, minutes tens/units).
- Latches a full frame of digits and rotates the active anode at a fixed refresh rate.
- Adds inter-digit ghost blanking, optional leading-zero suppression, and a blinking decimal-point "colon" between hours and minutes.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- DIGIT_HZ, 4_000, digit switch rate. DIV = CLK_HZ/DIGIT_HZ clocks per digit slot.
- BLINK_HZ, 1, colon blink rate. Phase toggles every CLK_HZ/(2*BLINK_HZ) clocks.
- BLANK_CYC, 1000, clocks at the start of each slot with all anodes off. Constraint: DIV >= BLANK_CYC+2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- d3  in  4  BCD, leftmost digit (hours tens)
- d2  in  4  BCD (hours units)
- d1  in  4  BCD (minutes tens)
- d0  in  4  BCD, rightmost digit (minutes units)
- blank_lead  in  1  1 = suppress d3 when it is 0
- dp_en  in  1  1 = enable blinking colon dp
- an  out  4  anodes, active-low; an[0] = rightmost digit
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high. All state is cleared on reset.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1; slot counter=0, scan index=0, blink counter=0, blink phase=0, shadow digits=0.
- Slot counter: counts 0..DIV-1. tick is asserted when it equals DIV-1; the counter then wraps to 0.
- Scan index: 2-bit; increments on tick, 3 wraps to 0. Index i drives an[i]; index 0 = d0.
- Shadow frame: on tick with index==3, the shadow register loads {d3,d2,d1,d0}. Inputs are otherwise ignored, so no tearing mid-frame. Consequence: after reset, 0000 is shown until the first wrap.
- Output computation: outputs are registered, computed from the pre-edge index/counter/shadow/blink. Latency is 1 clk from an index change to the corresponding an/seg change.
- Blank window: while slot counter < BLANK_CYC, an=1111, seg=1111111, dp=1.
- Active window: an has a single 0 at the bit equal to the index; seg = decode(shadow[index]).
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash 0111111
- Leading zero: blank_lead=1 and shadow d3==0 → during index 3, an stays 1111 and seg stays 1111111. Only d3 is suppressed; d2 is never suppressed.
- Colon: blink phase toggles each half period, free-running and independent of the scan. dp=0 only when dp_en=1, blink phase=1, index==2, and outside the blank window; dp=1 otherwise.
- blank_lead and dp_en are sampled every clock, not shadowed.
- Reset mid-slot: outputs go to reset values immediately (asynchronous). Scanning restarts at index 0 with the full blank window after release.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_* digit constants 0-9
  - SEG_BLANK, SEG_DASH
  - AN_OFF=4'b1111
  - typedef seg_t (logic [6:0])
  - typedef bcd_t (logic [3:0])
- One natural sub-module: bcd_to_seg7, a purely combinational bcd_t→seg_t decoder that includes the dash case. It is reusable by other display blocks.
- Top level keeps: slot counter, scan index, blink counter, shadow register, output registers.

Test Plan:
Bench parameters: CLK_HZ=1000, DIGIT_HZ=100 (DIV=10), BLINK_HZ=50 (toggle every 10 clk), BLANK_CYC=2.
- Reset: assert reset mid-slot with digits 1234 → same cycle an=1111, seg=1111111, dp=1; after release, first active an=1110 appears 3 clk later with seg=1000000.
- Normal scan: d=1,2,3,4, one full frame elapsed, then per slot:
  - an=1110 seg=0011001, then an=1101 seg=0110000, then an=1011 seg=0100100, then an=0111 seg=1111001
  - each active 8 clk, preceded by 2 clk of an=1111
- Anti-tearing: change to 0,5,5,9 during index 1 → displayed values stay 1234 until index returns to 0 after the next wrap, then show 0559.
- Leading zero: 05:59 with blank_lead=1 → an[3] never 0 over 3 frames. With blank_lead=0 → index 3 shows an=0111 seg=1000000.
- Invalid BCD: d1=4'hC → index 1 shows seg=0111111; the other digits are unaffected.
- Colon: dp_en=1 → dp=0 only during the active index-2 window while blink phase=1, and the pattern alternates every 10 clk. dp_en=0 → dp=1 at all times.
